mem_pipe_regs: RTL and testbench

- Parametrised N-stage register chain for the memory-stage pipeline, replacing the single fixed inter-stage register.
- Carries the same payload per stage: instruction type, pc, result, ROB id and valid.
- Adds valid/ready backpressure with bubble collapsing, a synchronous flush, and an asynchronous active-low reset.
- Sits between the cache/memory access stage and the writeback/ROB commit port.

---
 rtl/mem_pipe_regs_if.sv | 51 +++++
 rtl/mem_pipe_regs.sv | 172 +++++++++++++++++
 tb/tb_mem_pipe_regs.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pipe_regs_if.sv
// mem_pipe_regs_if: handshake and payload bundle for the memory-stage
// pipeline register chain. The upstream side carries in_valid/in_ready,
// the four payload fields and flush. The downstream side carries
// out_ready/valid_out and the stage DEPTH-1 payload.
// The slave modport is the pipeline's view of the bundle. The master
// modport is the view of the surrounding stages.
// The optional performance counters are controlled by MEM_PIPE_PERF_EN and
// are plain ports of mem_pipe_regs, not members of this bundle.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WITDH
`define ROB_ENTRY_WITDH 6
`endif

interface mem_pipe_regs_if #(
    parameter int WORD_SIZE       = `WORD_SIZE,
    parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
    parameter int ROB_ENTRY_WITDH = `ROB_ENTRY_WITDH
);
    // upstream (cache / memory access stage) side
    logic                       in_valid;
    logic                       in_ready;
    logic [INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [WORD_SIZE-1:0]       pc;
    logic [WORD_SIZE-1:0]       result;
    logic [ROB_ENTRY_WITDH-1:0] rob_id;
    logic                       flush;

    // downstream (writeback / ROB commit) side
    logic                       out_ready;
    logic                       valid_out;
    logic [INSTR_TYPE_SZ-1:0]   instruction_type_out;
    logic [WORD_SIZE-1:0]       pc_out;
    logic [WORD_SIZE-1:0]       result_out;
    logic [ROB_ENTRY_WITDH-1:0] rob_id_out;

    modport master (
        output in_valid, instruction_type, pc, result, rob_id, flush, out_ready,
        input  in_ready, valid_out, instruction_type_out, pc_out, result_out, rob_id_out
    );

    modport slave (
        input  in_valid, instruction_type, pc, result, rob_id, flush, out_ready,
        output in_ready, valid_out, instruction_type_out, pc_out, result_out, rob_id_out
    );
endinterface

// File: rtl/mem_pipe_regs.sv
// mem_pipe_regs: parametrised DEPTH-stage register chain between the memory
// access stage and the writeback / ROB commit port.
// - Behaviour: valid/ready backpressure with same-cycle bubble collapsing,
//   a synchronous flush, and an asynchronous active-low reset.
// - Stage 0 is the entry stage. Stage DEPTH-1 drives the outputs directly
//   from its registers.
// - Optional feature: when MEM_PIPE_PERF_EN is defined, the occupancy and
//   stall_cycles outputs are added.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WITDH
`define ROB_ENTRY_WITDH 6
`endif

module mem_pipe_regs #(
    parameter int WORD_SIZE       = `WORD_SIZE,
    parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
    parameter int ROB_ENTRY_WITDH = `ROB_ENTRY_WITDH,
    parameter int DEPTH           = 2        // legal range 1..8
) (
    input  logic                 clk,
    input  logic                 reset,      // asynchronous, active-low
    mem_pipe_regs_if.slave       bus
`ifdef MEM_PIPE_PERF_EN
    ,
    output logic [3:0]           occupancy,
    output logic [31:0]          stall_cycles
`endif
);

    // ------------------------------------------------------------------
    // Stage state: valid bit plus payload per stage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]           r_v;
    logic [INSTR_TYPE_SZ-1:0]   r_itype  [DEPTH];
    logic [WORD_SIZE-1:0]       r_pc     [DEPTH];
    logic [WORD_SIZE-1:0]       r_result [DEPTH];
    logic [ROB_ENTRY_WITDH-1:0] r_rob    [DEPTH];

    // ------------------------------------------------------------------
    // Handshake network
    // ------------------------------------------------------------------
    // w_acc[i] : stage i can take a new value at the next edge.
    //            The extra top bit w_acc[DEPTH] is the downstream ready,
    //            so every stage uses the same expression.
    // w_move[i]: stage i hands its entry onward at the next edge.
    logic [DEPTH:0]             w_acc;
    logic [DEPTH-1:0]           w_move;

    // Source seen by each stage. Stage 0 sees the upstream port.
    // Stage i>0 sees stage i-1.
    logic [DEPTH-1:0]           w_src_v;
    logic [INSTR_TYPE_SZ-1:0]   w_src_itype  [DEPTH];
    logic [WORD_SIZE-1:0]       w_src_pc     [DEPTH];
    logic [WORD_SIZE-1:0]       w_src_result [DEPTH];
    logic [ROB_ENTRY_WITDH-1:0] w_src_rob    [DEPTH];

    // Ready chain, resolved from the output stage back to the entry stage.
    // A hole at any stage opens every upstream stage in the same cycle.
    always_comb begin
        w_acc        = '0;
        w_move       = '0;
        w_acc[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_move[i] = r_v[i] & w_acc[i+1];
            w_acc[i]  = ~r_v[i] | w_move[i];
        end
    end

    // Source selection: upstream port for stage 0, previous stage otherwise.
    always_comb begin
        w_src_v[0]      = bus.in_valid;
        w_src_itype[0]  = bus.instruction_type;
        w_src_pc[0]     = bus.pc;
        w_src_result[0] = bus.result;
        w_src_rob[0]    = bus.rob_id;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_v[i]      = w_move[i-1];
            w_src_itype[i]  = r_itype[i-1];
            w_src_pc[i]     = r_pc[i-1];
            w_src_result[i] = r_result[i-1];
            w_src_rob[i]    = r_rob[i-1];
        end
    end

    // in_ready is held low while reset is asserted and during a flush cycle.
    // No entry is accepted on a cycle in which it would be killed at once.
    assign bus.in_ready = w_acc[0] & ~bus.flush & reset;

    // Stage registers: async clear, flush kills valids, otherwise per-stage
    // load/bubble/hold. Payload only changes when a valid entry lands, so
    // an emptied stage keeps its last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_itype[i]  <= '0;
                r_pc[i]     <= '0;
                r_result[i] <= '0;
                r_rob[i]    <= '0;
            end
        end else if (bus.flush) begin
            r_v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_acc[i]) begin
                    r_v[i] <= w_src_v[i];
                    if (w_src_v[i]) begin
                        r_itype[i]  <= w_src_itype[i];
                        r_pc[i]     <= w_src_pc[i];
                        r_result[i] <= w_src_result[i];
                        r_rob[i]    <= w_src_rob[i];
                    end else begin
                        r_itype[i]  <= r_itype[i];
                        r_pc[i]     <= r_pc[i];
                        r_result[i] <= r_result[i];
                        r_rob[i]    <= r_rob[i];
                    end
                end else begin
                    r_v[i] <= r_v[i];
                end
            end
        end
    end

    // The outputs come straight from the output-stage registers.
    assign bus.valid_out            = r_v[DEPTH-1];
    assign bus.instruction_type_out = r_itype[DEPTH-1];
    assign bus.pc_out               = r_pc[DEPTH-1];
    assign bus.result_out           = r_result[DEPTH-1];
    assign bus.rob_id_out           = r_rob[DEPTH-1];

`ifdef MEM_PIPE_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cycles;

    // Number of occupied stages.
    function automatic logic [3:0] count_valid(input logic [DEPTH-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    assign occupancy = count_valid(r_v);

    // Count the cycles in which the output entry is blocked by downstream.
    // The counter saturates and is cleared only by reset; flush leaves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 32'd0;
        end else if (r_v[DEPTH-1] && !bus.out_ready &&
                     (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_mem_pipe_regs.sv
// tb_mem_pipe_regs: scoreboard bench for mem_pipe_regs.
// Three instances (DEPTH = 1, 2, 3) share one stimulus stream. For each
// instance, every accepted entry is queued, and a monitor pops the queue
// and compares on each output handshake. Directed checks cover reset,
// latency, full/stall, bubble collapse, flush and asynchronous reset.
// When MEM_PIPE_PERF_EN is defined, the bench also checks occupancy and
// stall_cycles.

`timescale 1ns/1ps

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WITDH
`define ROB_ENTRY_WITDH 6
`endif

module tb_mem_pipe_regs;

    localparam int WS = `WORD_SIZE;
    localparam int IT = `INSTR_TYPE_SZ;
    localparam int RW = `ROB_ENTRY_WITDH;
    localparam int PW = IT + WS + WS + RW;
    localparam int ND = 3;                 // instance d has DEPTH d+1

    typedef logic [PW-1:0] pl_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          flush;
    logic          out_ready;
    logic [IT-1:0] itype;
    logic [WS-1:0] pc;
    logic [WS-1:0] result;
    logic [RW-1:0] rob;

    logic [ND-1:0] rdy;
    logic [ND-1:0] vout;
    pl_t           outp [ND];
    pl_t           q [ND][$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input pl_t act, input pl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < ND; g++) begin : gen
        mem_pipe_regs_if u_if ();
`ifdef MEM_PIPE_PERF_EN
        logic [3:0]  occ;
        logic [31:0] stl;
`endif
        assign u_if.in_valid         = in_valid;
        assign u_if.instruction_type = itype;
        assign u_if.pc               = pc;
        assign u_if.result           = result;
        assign u_if.rob_id           = rob;
        assign u_if.flush            = flush;
        assign u_if.out_ready        = out_ready;
        assign rdy[g]  = u_if.in_ready;
        assign vout[g] = u_if.valid_out;
        assign outp[g] = {u_if.instruction_type_out, u_if.pc_out,
                          u_if.result_out, u_if.rob_id_out};

        mem_pipe_regs #(.DEPTH(g + 1)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .bus          (u_if)
`ifdef MEM_PIPE_PERF_EN
            ,
            .occupancy    (occ),
            .stall_cycles (stl)
`endif
        );

        // Monitor: compare each delivered entry against the queue head.
        // A flush discards everything that was not handed off this cycle.
        always @(negedge clk) begin
            if (reset === 1'b1) begin
                if (vout[g] && out_ready) begin
                    if (q[g].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL d%0d_unexpected_out: got %0h, expected nothing", g + 1, outp[g]);
                    end else begin
                        chk($sformatf("d%0d_out", g + 1), outp[g], q[g].pop_front());
                    end
                end
                if (flush) q[g].delete();
            end
        end
    end

    function automatic logic [WS-1:0] pc_of(input int id);
        return WS'(32'h1000) + WS'(id * 4);
    endfunction

    task automatic drive(input logic v, input int id, input logic [WS-1:0] pcv);
        in_valid = v;
        itype    = id[IT-1:0];
        pc       = pcv;
        result   = WS'(32'hC0DE_0000) | WS'(id);
        rob      = id[RW-1:0];
    endtask

    // Move to the sampling point of the current cycle (just after negedge).
    task automatic half();
        @(negedge clk);
        #1;
    endtask

    // Record accepted entries, then advance past the next active edge.
    task automatic edge_();
        for (int d = 0; d < ND; d++) begin
            if (reset && in_valid && rdy[d]) q[d].push_back({itype, pc, result, rob});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, '0);
        for (int k = 0; k < n; k++) begin
            half();
            edge_();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  id;
        logic acc0;
`ifdef MEM_PIPE_PERF_EN
        logic [31:0] s0;
`endif
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 63, pc_of(63));
        repeat (2) @(posedge clk);
        #1;

        // reset state: in_ready gated even with in_valid high
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_vout_d%0d", d + 1), pl_t'(vout[d]), '0);
            chk($sformatf("rst_rdy_d%0d", d + 1), pl_t'(rdy[d]), '0);
            chk($sformatf("rst_payload_d%0d", d + 1), outp[d], '0);
        end
        drive(1'b0, 0, '0);
        reset     = 1'b1;
        out_ready = 1'b1;

        // stream 1..4 at full rate
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, pc_of(i));
            half();
            for (int d = 0; d < ND; d++) chk($sformatf("stream_rdy_d%0d", d + 1), pl_t'(rdy[d]), pl_t'(1));
            edge_();
            chk("stream_vout_d1", pl_t'(vout[0]), pl_t'(1));
            chk("stream_rob_d1", pl_t'(outp[0][RW-1:0]), pl_t'(i));
            chk("stream_vout_d2", pl_t'(vout[1]), pl_t'(i >= 2));
            if (i >= 2) chk("stream_rob_d2", pl_t'(outp[1][RW-1:0]), pl_t'(i - 1));
            chk("stream_vout_d3", pl_t'(vout[2]), pl_t'(i >= 3));
        end
        idle(5);

        // backpressure: DEPTH=3 takes 5,6,7 and refuses 8
        out_ready = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            drive(1'b1, i, pc_of(i));
            half();
            chk("bp_rdy_d3", pl_t'(rdy[2]), pl_t'(i != 8));
            chk("bp_rdy_d2", pl_t'(rdy[1]), pl_t'(i <= 6));
            chk("bp_rdy_d1", pl_t'(rdy[0]), pl_t'(i == 5));
            edge_();
        end
        out_ready = 1'b1;
        half();
        chk("full_pushpop_rdy_d3", pl_t'(rdy[2]), pl_t'(1));
        edge_();
        idle(6);

        // bubble collapse: 9, idle, 10 with downstream stalled
        out_ready = 1'b0;
        drive(1'b1, 9, pc_of(9));   half(); edge_();
        drive(1'b0, 0, '0);         half(); edge_();
        drive(1'b1, 10, pc_of(10)); half(); edge_();
        drive(1'b0, 0, '0);         half(); edge_();
        chk("bubble_vout_d3", pl_t'(vout[2]), pl_t'(1));
        chk("bubble_rob_d3", pl_t'(outp[2][RW-1:0]), pl_t'(9));
        chk("bubble_rdy_d3", pl_t'(rdy[2]), pl_t'(1));
`ifdef MEM_PIPE_PERF_EN
        chk("bubble_occ_d3", pl_t'(gen[2].occ), pl_t'(2));
        s0 = gen[2].stl;
`endif
        idle(2);
        chk("bubble_hold_rob_d3", pl_t'(outp[2][RW-1:0]), pl_t'(9));
`ifdef MEM_PIPE_PERF_EN
        chk("bubble_stall_d3", pl_t'(gen[2].stl), pl_t'(s0 + 32'd2));
`endif
        out_ready = 1'b1;
        idle(6);

        // flush: DEPTH=2 full with 0x100/0x104, new entry offered during flush
        out_ready = 1'b0;
        drive(1'b1, 11, 32'h100); half(); edge_();
        drive(1'b1, 12, 32'h104); half(); edge_();
        chk("flush_pre_vout_d2", pl_t'(vout[1]), pl_t'(1));
        chk("flush_pre_pc_d2", pl_t'(outp[1][RW+WS +: WS]), pl_t'(32'h100));
        drive(1'b1, 13, 32'h108);
        flush = 1'b1;
        half();
        for (int d = 0; d < ND; d++) chk($sformatf("flush_rdy_d%0d", d + 1), pl_t'(rdy[d]), '0);
        edge_();
        flush = 1'b0;
        drive(1'b0, 0, '0);
        for (int d = 0; d < ND; d++) chk($sformatf("flush_vout_d%0d", d + 1), pl_t'(vout[d]), '0);
        // flush with a handoff on the same cycle: the head is still delivered
        drive(1'b1, 14, pc_of(14)); half(); edge_();
        drive(1'b1, 15, pc_of(15)); half(); edge_();
        drive(1'b0, 0, '0);
        flush     = 1'b1;
        out_ready = 1'b1;
        half();
        edge_();
        flush = 1'b0;
        for (int d = 0; d < ND; d++) chk($sformatf("flush2_vout_d%0d", d + 1), pl_t'(vout[d]), '0);
        idle(4);

        // asynchronous reset between edges with two entries held
        out_ready = 1'b0;
        drive(1'b1, 20, pc_of(20)); half(); edge_();
        drive(1'b1, 21, pc_of(21)); half(); edge_();
        drive(1'b0, 0, '0);
        half();
        chk("arst_pre_vout_d2", pl_t'(vout[1]), pl_t'(1));
        #1;
        reset = 1'b0;
        for (int d = 0; d < ND; d++) q[d].delete();
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("arst_vout_d%0d", d + 1), pl_t'(vout[d]), '0);
            chk($sformatf("arst_payload_d%0d", d + 1), outp[d], '0);
            chk($sformatf("arst_rdy_d%0d", d + 1), pl_t'(rdy[d]), '0);
        end
`ifdef MEM_PIPE_PERF_EN
        chk("arst_stall_d3", pl_t'(gen[2].stl), '0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        // DEPTH=1 with out_ready toggling, upstream holds until accepted
        id = 30;
        for (int c = 0; c < 8; c++) begin
            out_ready = (c % 2 == 0);
            drive(1'b1, id, pc_of(id));
            half();
            chk("d1_toggle_rdy", pl_t'(rdy[0]), pl_t'(out_ready));
            acc0 = rdy[0];
            edge_();
            chk("d1_toggle_vout", pl_t'(vout[0]), pl_t'(1));
            if (acc0) begin
                chk("d1_toggle_pc", pl_t'(outp[0][RW+WS +: WS]), pl_t'(pc_of(id)));
                id++;
            end
        end

        // drain, bounded
        drive(1'b0, 0, '0);
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && vout == '0) break;
            half();
            edge_();
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("drain_queue_d%0d", d + 1), pl_t'(q[d].size()), '0);
            chk($sformatf("drain_vout_d%0d", d + 1), pl_t'(vout[d]), '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
